fifo_write_ctrl: RTL and testbench

FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

---
 rtl/fifo_write_ctrl.sv | 131 +++++++++++++
 tb/tb_fifo_write_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_ctrl.sv
// FIFO write front end: 2-entry skid buffer feeding a registered FIFO write port, paced by full/almost-full flags.
// Latency: accept-to-valid_write one cycle when idle in RUN. Backpressure: s_ready drops while the skid entry is occupied.
module fifo_write_ctrl #(
    parameter int SIZE  = 8,
    parameter int CNT_W = 16
) (
    input  logic             w_clk,
    input  logic             n_rst,
    input  logic             s_valid,
    input  logic [SIZE-1:0]  s_data,
    output logic             s_ready,
    input  logic             f_flag,
    input  logic             almost_full_flag,
    output logic [SIZE-1:0]  data_in,
    output logic             valid_write,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             ovf_err
);

    typedef enum logic [1:0] {RUN, PACE, HOLD} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SIZE-1:0] main_dat;
    logic [SIZE-1:0] skid_dat;
    logic            main_vld;
    logic            skid_vld;
    logic            out_full;

    logic [SIZE-1:0] main_dat_nxt;
    logic [SIZE-1:0] skid_dat_nxt;
    logic [SIZE-1:0] data_in_nxt;
    logic            main_vld_nxt;
    logic            skid_vld_nxt;
    logic            out_full_nxt;
    logic            valid_write_nxt;
    logic            accept;
    logic            commit;
    logic            load;
    logic            allow;
    logic            stall_inc;

    always_comb begin
        state_nxt       = RUN;
        main_dat_nxt    = main_dat;
        skid_dat_nxt    = skid_dat;
        main_vld_nxt    = main_vld;
        skid_vld_nxt    = skid_vld;
        data_in_nxt     = data_in;
        out_full_nxt    = out_full;
        valid_write_nxt = 1'b0;
        allow           = 1'b0;

        if (f_flag)
            state_nxt = HOLD;
        else if (almost_full_flag)
            state_nxt = PACE;

        accept = s_valid && s_ready;
        commit = valid_write && !f_flag;
        // The output stage refills only when it is (or is becoming) free and the FIFO is not full.
        load   = main_vld && (state_nxt != HOLD) && (!out_full || commit);

        if (load) begin
            data_in_nxt  = main_dat;
            out_full_nxt = 1'b1;
        end else if (commit) begin
            out_full_nxt = 1'b0;
        end

        if (load) begin
            main_dat_nxt = skid_dat;
            main_vld_nxt = skid_vld;
            skid_vld_nxt = 1'b0;
        end
        if (accept) begin
            if (!main_vld_nxt) begin
                main_dat_nxt = s_data;
                main_vld_nxt = 1'b1;
            end else begin
                skid_dat_nxt = s_data;
                skid_vld_nxt = 1'b1;
            end
        end

        // PACE grants a write on entry and after any cycle without one.
        if (state_nxt == RUN)
            allow = 1'b1;
        else if (state_nxt == PACE)
            allow = (state != PACE) || !valid_write;
        valid_write_nxt = out_full_nxt && allow;

        stall_inc = ((state == PACE) || (state == HOLD)) && !valid_write
                    && (out_full || main_vld || skid_vld);
    end

    always_ff @(posedge w_clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= RUN;
            main_dat    <= '0;
            skid_dat    <= '0;
            main_vld    <= 1'b0;
            skid_vld    <= 1'b0;
            out_full    <= 1'b0;
            data_in     <= '0;
            valid_write <= 1'b0;
            s_ready     <= 1'b0;
            wr_count    <= '0;
            stall_count <= '0;
            ovf_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            main_dat    <= main_dat_nxt;
            skid_dat    <= skid_dat_nxt;
            main_vld    <= main_vld_nxt;
            skid_vld    <= skid_vld_nxt;
            out_full    <= out_full_nxt;
            data_in     <= data_in_nxt;
            valid_write <= valid_write_nxt;
            s_ready     <= !skid_vld_nxt;
            if (commit)
                wr_count <= wr_count + CNT_W'(1);
            if (stall_inc && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
            if (valid_write && f_flag)
                ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed scenarios plus randomized traffic, checked against a word-level scoreboard model.
module tb_fifo_write_ctrl;
    localparam int SIZE  = 16;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int S_RUN = 0, S_PACE = 1, S_HOLD = 2;

    logic             w_clk = 1'b0;
    logic             n_rst;
    logic             s_valid;
    logic [SIZE-1:0]  s_data;
    logic             s_ready;
    logic             f_flag;
    logic             almost_full_flag;
    logic [SIZE-1:0]  data_in;
    logic             valid_write;
    logic [CNT_W-1:0] wr_count;
    logic [CNT_W-1:0] stall_count;
    logic             ovf_err;

    int checks   = 0;
    int failures = 0;

    logic [SIZE-1:0] sb[$];
    int exp_wr, exp_stall, stall_total, accepts, commits, st;
    logic exp_ovf;

    always #5 w_clk = ~w_clk;

    fifo_write_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .w_clk(w_clk), .n_rst(n_rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .f_flag(f_flag), .almost_full_flag(almost_full_flag),
        .data_in(data_in), .valid_write(valid_write), .wr_count(wr_count),
        .stall_count(stall_count), .ovf_err(ovf_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: capture pre-edge handshake, advance the model, compare after the edge.
    task automatic tick();
        logic            vw, sr, sv, ff, af;
        logic [SIZE-1:0] d, sd;
        logic [SIZE-1:0] want;
        int              new_st;
        bit              pending;
        vw = valid_write; sr = s_ready; sv = s_valid; sd = s_data;
        ff = f_flag; af = almost_full_flag; d = data_in;
        pending = (sb.size() > 0);
        @(posedge w_clk);
        #1;
        if (vw && !ff) begin
            commits++;
            exp_wr = (exp_wr + 1) % (CMAX + 1);
            chk("commit_has_word", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                want = sb.pop_front();
                chk("commit_data", 32'(d), 32'(want));
            end
        end
        if (vw && ff) exp_ovf = 1'b1;
        if ((st == S_PACE || st == S_HOLD) && !vw && pending) begin
            stall_total++;
            if (exp_stall < CMAX) exp_stall++;
        end
        if (sv && sr) begin
            sb.push_back(sd);
            accepts++;
        end
        new_st = ff ? S_HOLD : (af ? S_PACE : S_RUN);
        if (new_st == S_HOLD) chk("hold_no_write", 32'(valid_write), 32'd0);
        if (new_st == S_PACE && st == S_PACE && vw) chk("pace_spacing", 32'(valid_write), 32'd0);
        st = new_st;
        chk("wr_count", 32'(wr_count), 32'(exp_wr));
        chk("stall_count", 32'(stall_count), 32'(exp_stall));
        chk("ovf_err", 32'(ovf_err), 32'(exp_ovf));
        if (sb.size() >= 3) chk("ready_low_full", 32'(s_ready), 32'd0);
        if (sb.size() <= 1) chk("ready_high", 32'(s_ready), 32'd1);
        @(negedge w_clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_vw"}, 32'(valid_write), 32'd0);
        chk({tag, "_data_in"}, 32'(data_in), 32'd0);
        chk({tag, "_wr"}, 32'(wr_count), 32'd0);
        chk({tag, "_stall"}, 32'(stall_count), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf_err), 32'd0);
    endtask

    task automatic do_reset();
        n_rst = 1'b0; s_valid = 1'b0; s_data = '0;
        f_flag = 1'b0; almost_full_flag = 1'b0;
        #1;
        check_zero("rst_async");
        sb.delete();
        exp_wr = 0; exp_stall = 0; exp_ovf = 1'b0; st = S_RUN;
        @(posedge w_clk);
        @(negedge w_clk);
        check_zero("rst_held");
        n_rst = 1'b1;
        tick();
    endtask

    initial begin
        logic [SIZE-1:0] vec [4];
        int a0, c0, s0, budget;
        vec[0] = 16'd20; vec[1] = 16'd503; vec[2] = 16'd90; vec[3] = 16'd10;
        stall_total = 0; accepts = 0; commits = 0;
        n_rst = 1'b1; s_valid = 1'b0; s_data = '0; f_flag = 1'b0; almost_full_flag = 1'b0;
        #2;
        do_reset();

        // Streaming with flags low: one-cycle latency, back-to-back writes.
        s_valid = 1'b1; s_data = vec[0];
        tick();
        chk("lat_not_yet", 32'(valid_write), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) s_data = vec[i];
            else s_valid = 1'b0;
            tick();
            chk($sformatf("stream_vw%0d", i), 32'(valid_write), 32'd1);
            chk($sformatf("stream_dat%0d", i), 32'(data_in), 32'(vec[i-1]));
        end
        tick();
        chk("stream_idle", 32'(valid_write), 32'd0);
        chk("stream_wr4", 32'(wr_count), 32'd4);

        // Almost-full pacing over an 8-cycle window.
        do_reset();
        c0 = commits; s0 = stall_total; a0 = accepts;
        almost_full_flag = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 16'(100 + accepts - a0);
            tick();
        end
        chk("pace_commits_le4", 32'((commits - c0) <= 4), 32'd1);
        chk("pace_stall_ge4", 32'((stall_total - s0) >= 4), 32'd1);
        chk("pace_stall_dut_ge4", 32'(stall_count >= 4), 32'd1);
        almost_full_flag = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("pace_drained", 32'(sb.size()), 32'd0);

        // Full flag held while the source keeps offering.
        do_reset();
        c0 = commits; a0 = accepts;
        f_flag = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = 16'(accepts - a0);
            tick();
            chk("full_vw_low", 32'(valid_write), 32'd0);
        end
        chk("full_two_accepts", 32'(accepts - a0), 32'd2);
        chk("full_ready_low", 32'(s_ready), 32'd0);
        f_flag = 1'b0;
        budget = 60;
        while ((accepts - a0) < 9 && budget > 0) begin
            s_data = 16'(accepts - a0);
            tick();
            budget--;
        end
        chk("full_refill_in_budget", 32'(budget > 0), 32'd1);
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("full_nine_commits", 32'(commits - c0), 32'd9);
        chk("full_wr9", 32'(wr_count), 32'd9);

        // Full flag rising on the write edge: retry without loss.
        do_reset();
        s_valid = 1'b1; s_data = 16'd55;
        tick();
        s_valid = 1'b0;
        tick();
        chk("ovf_pre_vw", 32'(valid_write), 32'd1);
        chk("ovf_pre_dat", 32'(data_in), 32'd55);
        f_flag = 1'b1;
        tick();
        chk("ovf_set", 32'(ovf_err), 32'd1);
        chk("ovf_hold_dat", 32'(data_in), 32'd55);
        chk("ovf_no_commit", 32'(wr_count), 32'd0);
        tick();
        tick();
        f_flag = 1'b0;
        tick();
        chk("ovf_retry_vw", 32'(valid_write), 32'd1);
        chk("ovf_retry_dat", 32'(data_in), 32'd55);
        tick();
        chk("ovf_wr_once", 32'(wr_count), 32'd1);

        // Reset with two words buffered discards them and clears the sticky flag.
        f_flag = 1'b1; s_valid = 1'b1; s_data = 16'd77;
        tick();
        s_data = 16'd78;
        tick();
        chk("mid_ovf_sticky", 32'(ovf_err), 32'd1);
        chk("mid_buffered", 32'(sb.size()), 32'd2);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_write", 32'(valid_write), 32'd0);
        end

        // Randomized traffic; counters wrap and saturate at CNT_W bits.
        for (int i = 0; i < 400; i++) begin
            s_valid          = ($urandom_range(0, 3) != 0);
            s_data           = 16'($urandom);
            f_flag           = ($urandom_range(0, 7) == 0);
            almost_full_flag = ($urandom_range(0, 3) == 0);
            tick();
        end
        s_valid = 1'b0; f_flag = 1'b0; almost_full_flag = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("rand_drained", 32'(sb.size()), 32'd0);
        if (stall_total >= CMAX) chk("stall_saturated", 32'(stall_count), 32'(CMAX));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
